// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory loader: FSM state encoding
// and the default word geometry.
package loader_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_DEF      = 1024;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles MSB-first stream bytes into one instruction word; word is combinational
// so the top can capture the completed word on the same edge as the last byte.
module word_packer #(
  parameter int DATA_W = loader_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              strobe,
  input  logic              clear,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = $clog2(BPW + 1);

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  assign word      = (shift_q << 8) | DATA_W'(byte_in);
  assign word_full = strobe && (cnt_q == CNT_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (strobe) begin
      shift_q <= word;
      cnt_q   <= word_full ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// one word at a time, holding the CPU until the load finishes.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [15:0]       len_next;
  logic [7:0]        chk_q;
  logic [ADDR_W:0]   ww_q;
  logic              done_q, error_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              hs, restart, last_word, too_long;
  logic [DATA_W-1:0] packed_word;
  logic              word_full;

  assign hs        = byte_valid && byte_ready;
  assign restart   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign len_next  = {len_hi_q, byte_in};
  assign too_long  = 32'(len_next) > 32'(DEPTH);
  assign last_word = (32'(ww_q) + 32'd1) == 32'(len_q);

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .strobe    (hs && state_q == DATA),
    .clear     (restart),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HDR_HI;
      HDR_HI:          if (hs) state_d = HDR_LO;
      HDR_LO: begin
        if (hs) begin
          if (len_next == 16'd0) state_d = CHK;
          else if (too_long)     state_d = ERR;
          else                   state_d = DATA;
        end
      end
      DATA:            if (hs && word_full) state_d = WRITE;
      WRITE:           state_d = last_word ? CHK : DATA;
      CHK:             if (hs) state_d = (byte_in == chk_q) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA, CHK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
      end
      WRITE: begin
        wr_en    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // The completed word and its address are latched when the last byte arrives,
  // so wr_addr/wr_data are stable through the WRITE cycle and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q  <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      ww_q      <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (restart) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ww_q    <= '0;
            chk_q   <= '0;
          end
        end
        HDR_HI: if (hs) len_hi_q <= byte_in;
        HDR_LO: begin
          if (hs) begin
            len_q <= len_next;
            if (len_next != 16'd0 && too_long) error_q <= 1'b1;
          end
        end
        DATA: begin
          if (hs) begin
            chk_q <= chk_q ^ byte_in;
            if (word_full) begin
              wr_addr_q <= ww_q[ADDR_W-1:0];
              wr_data_q <= packed_word;
            end
          end
        end
        WRITE: ww_q <= ww_q + 1'b1;
        CHK: begin
          if (hs) begin
            if (byte_in == chk_q) done_q  <= 1'b1;
            else                  error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected memory writes are queued as frames
// are sent and a negedge monitor pops and compares each write strobe.
module tb_instr_mem_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_written;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];
  int          tests = 0;
  int          fails = 0;

  instr_mem_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest queued expectation and show the bubble.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                 wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check_output("wr_data", wr_data, mon_e.data);
        check_output("ready_bubble", 32'(byte_ready), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gapped);
    logic r;
    int   budget;
    if (gapped) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    budget     = 50;
    do begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!r && budget > 0);
    byte_valid = 1'b0;
    if (!r) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake_timeout: got ready=0, expected ready=1");
    end
  endtask

  // Sends start + full frame built from frame_words; the checksum is modelled here.
  task automatic send_frame(input int n, input bit gapped, input bit bad_chk,
                            input int start_at);
    logic [7:0]  chk;
    logic [31:0] w;
    logic [15:0] len;
    wr_t         e;
    int          cnt;
    chk = 8'h00;
    cnt = 0;
    len = 16'(n);
    pulse_start();
    check_output("hold_on_start", 32'(cpu_hold), 32'd1);
    check_output("done_cleared", 32'(done), 32'd0);
    check_output("error_cleared", 32'(error), 32'd0);
    check_output("ww_cleared", 32'(words_written), 32'd0);
    send_byte(len[15:8], gapped);
    send_byte(len[7:0], gapped);
    for (int i = 0; i < n; i++) begin
      w      = frame_words[i];
      e.addr = ADDR_W'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int j = 3; j >= 0; j--) begin
        if (cnt == start_at) pulse_start();
        send_byte(w[8*j +: 8], gapped);
        chk = chk ^ w[8*j +: 8];
        cnt++;
      end
    end
    send_byte(bad_chk ? (chk ^ 8'h01) : chk, gapped);
  endtask

  task automatic check_frame_end(input string tag, input bit exp_done, input bit exp_err,
                                 input int exp_ww);
    check_output({tag, "_done"}, 32'(done), 32'(exp_done));
    check_output({tag, "_error"}, 32'(error), 32'(exp_err));
    check_output({tag, "_ww"}, 32'(words_written), 32'(exp_ww));
    check_output({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_output({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_hold", 32'(cpu_hold), 32'd0);
    check_output("rst_ready", 32'(byte_ready), 32'd0);
    check_output("rst_wr_en", 32'(wr_en), 32'd0);
    check_output("rst_ww", 32'(words_written), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word program, checksum 0x8E.
    frame_words = '{32'h20010005, 32'h8C220004};
    send_frame(2, 1'b0, 1'b0, -1);
    check_frame_end("n2", 1'b1, 1'b0, 2);

    // Empty program, good then bad checksum.
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame_end("n0_ok", 1'b1, 1'b0, 0);
    send_frame(0, 1'b0, 1'b1, -1);
    check_frame_end("n0_bad", 1'b0, 1'b1, 0);

    // Oversize length: error straight from the header, nothing consumed after.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    check_output("big_error", 32'(error), 32'd1);
    check_output("big_done", 32'(done), 32'd0);
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("big_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check_frame_end("big", 1'b0, 1'b1, 0);

    // Three words with random gaps between bytes.
    frame_words = '{32'h00000013, 32'hDEADBEEF, 32'h12345678};
    send_frame(3, 1'b1, 1'b0, -1);
    check_frame_end("gap", 1'b1, 1'b0, 3);

    // Reset after five data bytes: one write done, rest aborted.
    frame_words = '{32'h11223344, 32'h55667788};
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    mon_e.addr = '0;
    mon_e.data = 32'h11223344;
    exp_q.push_back(mon_e);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("abort_hold", 32'(cpu_hold), 32'd0);
    check_output("abort_ready", 32'(byte_ready), 32'd0);
    check_output("abort_wr_en", 32'(wr_en), 32'd0);
    check_output("abort_ww", 32'(words_written), 32'd0);
    check_output("abort_wr_addr", 32'(wr_addr), 32'd0);
    check_output("abort_wr_data", wr_data, 32'd0);
    check_output("abort_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_words = '{32'hCAFEF00D};
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame_end("reload", 1'b1, 1'b0, 1);

    // Start pulsed mid-data must be ignored.
    frame_words = '{32'h0BADF00D, 32'h00400093};
    send_frame(2, 1'b0, 1'b0, 3);
    check_frame_end("midstart", 1'b1, 1'b0, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
